awgn_channel: RTL and testbench
===============================

AWGN_CHANNEL -- requirements
Module: awgn_channel

Interface
REQ-001 Parameter DW, default 24: signed I/Q sample width.
REQ-002 Parameter NOISE_SHIFT, default 0: left shift applied to scaled noise before the add (0..DW-12).
REQ-003 Parameter SEED_DEFAULT, default 32'hACE1_2468: LFSR seed used after reset and whenever a zero seed is loaded.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  reset, synchronous, active-low; clock clk.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_ready  out  1  block accepts a sample this cycle.
REQ-008 in_i, in_q  in  DW each  signed input sample.
REQ-009 snr_db  in  4  per-sample SNR select 0..15 dB, captured with the sample.
REQ-010 noise_en  in  1  per-sample; 0 = bypass (zero noise).
REQ-011 seed_load  in  1  single-cycle pulse reloading both LFSRs.
REQ-012 seed  in  32  seed value used on seed_load.
REQ-013 out_valid  out  1  output sample valid.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 out_i, out_q  out  DW each  signed noisy sample.
REQ-016 sample_cnt  out  32  count of output handshakes, saturating at 32'hFFFF_FFFF.

Function
REQ-017 Handshake: input transfer on in_valid&in_ready; output transfer on out_valid&out_ready; out_i/out_q stable while out_valid&!out_ready.
REQ-018 Pipeline: 3 stages, global advance = !out_valid | out_ready; in_ready = advance; valid bits shift on advance; latency exactly 3 cycles from input transfer to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-019 Noise source: two 32-bit Fibonacci LFSRs (I and Q), polynomial x^32+x^22+x^2+x+1; I seeded with seed, Q with ~seed; each advances one step only on an input transfer.
REQ-020 Gaussian approximation per channel: z = b0+b1+b2+b3 - 510, where bk are the four unsigned bytes of the LFSR state at transfer time; z is 11-bit signed, range -510..510.
REQ-021 Scaling: n = (z * SIGMA[snr_db]) >>> 7 (arithmetic), then n <<< NOISE_SHIFT; n forced to 0 when the sample's noise_en=0.
REQ-022 SIGMA[k] = round(90.51 * 10^(-k/20)), k=0..15 (k=0: 91, k=3: 64, k=8: 36); 7-bit unsigned.
REQ-023 Output: out = sat_DW(in + n), saturating to [-2^(DW-1), 2^(DW-1)-1]; no wrap-around.
REQ-024 seed_load: both LFSRs load on the next edge; zero seed replaced by SEED_DEFAULT; when seed_load coincides with an input transfer, that sample uses the pre-load state and the load wins (step discarded).
REQ-025 snr_db and noise_en travel with the sample; changing them mid-stream affects only samples transferred afterwards.
REQ-026 sample_cnt increments by 1 per output transfer, holds at max.

Reset
REQ-027 On reset=0 at a clock edge: all valid bits 0, out_valid=0, out_i=out_q=0, sample_cnt=0, LFSR I=SEED_DEFAULT, LFSR Q=~SEED_DEFAULT.
REQ-028 in_ready is 1 during and after reset (pipeline empty); inputs presented while reset=0 are ignored.
REQ-029 Reset mid-operation discards all in-flight samples; no output transfer occurs in the cycle reset is sampled low.

Structure
REQ-030 Shared package awgn_pkg holds: SIGMA table (16 x 7-bit), LFSR tap constant, SEED_DEFAULT default, SNR width constant.
REQ-031 One sub-module awgn_lfsr32 (load, step, state out), instantiated twice; scaling/saturation stays inline.

Verification
REQ-032 Reset: hold reset=0 3 cycles -> out_valid=0, out_i=out_q=0, sample_cnt=0, in_ready=1.
REQ-033 Bypass: noise_en=0, in_i=1000, in_q=-1000 at cycle 0, out_ready=1 -> out_valid at cycle 3 with out_i=1000, out_q=-1000.
REQ-034 Saturation: DW=24, NOISE_SHIFT=4, in_i=8388607, 1000 samples noise_en=1 snr_db=0 -> out_i never exceeds 8388607, never wraps negative.
REQ-035 Backpressure: stream 10 samples, drop out_ready for 5 cycles -> in_ready=0 while full, out data held stable, all 10 samples delivered in order, sample_cnt=10.
REQ-036 Statistics: 65536 zero-input samples, snr_db=0, NOISE_SHIFT=0 -> mean within +-2 LSB, std 104.5 +-3%; snr_db=8 -> std 41.6 +-3%.
REQ-037 Seeding: seed_load with seed=0x12345678, run 256 samples twice -> identical sequences; seed=0 -> sequence equals post-reset sequence.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared constants for the AWGN channel: noise scaling table, LFSR taps, default seed
// and the byte-sum Gaussian approximation.
package awgn_pkg;

  localparam int unsigned SnrW = 4;
  localparam logic [31:0] SeedDefault = 32'hACE1_2468;

  // x^32 + x^22 + x^2 + x + 1: feedback from state bits 31, 21, 1 and 0
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  // round(90.51 * 10^(-k/20)), k = 0..15
  localparam logic [6:0] SigmaTable [16] = '{
    7'd91, 7'd81, 7'd72, 7'd64, 7'd57, 7'd51, 7'd45, 7'd40,
    7'd36, 7'd32, 7'd29, 7'd26, 7'd23, 7'd20, 7'd18, 7'd16
  };

  // Sum of four uniform bytes, re-centred to -510..510
  function automatic logic signed [10:0] gauss_z(input logic [31:0] s);
    logic [10:0] sum;
    sum = 11'(s[7:0]) + 11'(s[15:8]) + 11'(s[23:16]) + 11'(s[31:24]);
    return $signed(sum - 11'd510);
  endfunction

endpackage

// File: rtl/awgn_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous load (priority over step) and single-step advance.
module awgn_lfsr32
  import awgn_pkg::*;
#(
  parameter logic [31:0] ResetVal = SeedDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = {state_q[30:0], ^(state_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ResetVal;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/awgn_channel.sv
// AWGN channel: adds scaled pseudo-Gaussian LFSR noise to I/Q samples through a 3-stage
// pipeline that stalls as a whole, with saturating output.
module awgn_channel
  import awgn_pkg::*;
#(
  parameter int unsigned DW           = 24,
  parameter int unsigned NOISE_SHIFT  = 0,
  parameter logic [31:0] SEED_DEFAULT = SeedDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_i,
  input  logic [DW-1:0]   in_q,
  input  logic [SnrW-1:0] snr_db,
  input  logic            noise_en,
  input  logic            seed_load,
  input  logic [31:0]     seed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_i,
  output logic [DW-1:0]   out_q,
  output logic [31:0]     sample_cnt
);

  logic                 advance, in_xfer, out_xfer;
  logic [31:0]          seed_eff, lfsr_i, lfsr_q;
  logic                 v1_q, v2_q, v3_q;
  logic signed [DW-1:0] s1_i_q, s1_q_q, s2_i_q, s2_q_q, n2_i_q, n2_q_q;
  logic signed [DW-1:0] out_i_q, out_q_q;
  logic signed [10:0]   z1_i_q, z1_q_q;
  logic [SnrW-1:0]      snr1_q;
  logic                 nen1_q;
  logic signed [DW-1:0] n_i_d, n_q_d, out_i_d, out_q_d;
  logic [31:0]          cnt_d, cnt_q;

  function automatic logic signed [DW-1:0] scale_noise(input logic signed [10:0] z,
                                                       input logic [SnrW-1:0] snr);
    logic signed [18:0] prod;
    prod = 19'(z) * 19'($signed({1'b0, SigmaTable[snr]}));
    return DW'(prod >>> 7) <<< NOISE_SHIFT;
  endfunction

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1]) begin
      return sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    return sum[DW-1:0];
  endfunction

  assign advance  = !v3_q || out_ready;
  // Empty pipeline during reset, so always ready then
  assign in_ready = advance || !reset;
  assign in_xfer  = in_valid && advance && reset;
  assign out_xfer = v3_q && out_ready && reset;
  assign seed_eff = (seed == '0) ? SEED_DEFAULT : seed;

  awgn_lfsr32 #(
    .ResetVal(SEED_DEFAULT)
  ) u_lfsr_i (
    .clk       (clk),
    .reset     (reset),
    .load_i    (seed_load),
    .load_val_i(seed_eff),
    .step_i    (in_xfer),
    .state_o   (lfsr_i)
  );

  awgn_lfsr32 #(
    .ResetVal(~SEED_DEFAULT)
  ) u_lfsr_q (
    .clk       (clk),
    .reset     (reset),
    .load_i    (seed_load),
    .load_val_i(~seed_eff),
    .step_i    (in_xfer),
    .state_o   (lfsr_q)
  );

  always_comb begin
    n_i_d   = nen1_q ? scale_noise(z1_i_q, snr1_q) : '0;
    n_q_d   = nen1_q ? scale_noise(z1_q_q, snr1_q) : '0;
    out_i_d = sat_add(s2_i_q, n2_i_q);
    out_q_d = sat_add(s2_q_q, n2_q_q);
    cnt_d   = (out_xfer && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_i_q  <= '0;
      s1_q_q  <= '0;
      z1_i_q  <= '0;
      z1_q_q  <= '0;
      snr1_q  <= '0;
      nen1_q  <= 1'b0;
      s2_i_q  <= '0;
      s2_q_q  <= '0;
      n2_i_q  <= '0;
      n2_q_q  <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        v1_q <= in_xfer;
        v2_q <= v1_q;
        v3_q <= v2_q;
        if (in_xfer) begin
          s1_i_q <= in_i;
          s1_q_q <= in_q;
          z1_i_q <= gauss_z(lfsr_i);
          z1_q_q <= gauss_z(lfsr_q);
          snr1_q <= snr_db;
          nen1_q <= noise_en;
        end
        if (v1_q) begin
          s2_i_q <= s1_i_q;
          s2_q_q <= s1_q_q;
          n2_i_q <= n_i_d;
          n2_q_q <= n_q_d;
        end
        if (v2_q) begin
          out_i_q <= out_i_d;
          out_q_q <= out_q_d;
        end
      end
    end
  end

  assign out_valid  = v3_q;
  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_awgn_channel.sv
// Randomised self-checking bench for awgn_channel against a sample-level reference model.
module tb_awgn_channel;

  localparam int unsigned DW      = 24;
  localparam int unsigned NS      = 4;
  localparam logic [31:0] SeedDef = 32'hACE1_2468;
  localparam longint      MaxV    = (longint'(1) << (DW - 1)) - 1;
  localparam longint      MinV    = -(longint'(1) << (DW - 1));

  logic                 clk;
  logic                 reset;
  logic                 in_valid, in_ready, out_valid, out_ready;
  logic signed [DW-1:0] in_i, in_q, out_i, out_q;
  logic [3:0]           snr_db;
  logic                 noise_en, seed_load;
  logic [31:0]          seed, sample_cnt;

  int          checks, errors;
  logic [31:0] m_lfsr_i, m_lfsr_q;
  longint      exp_i_q[$], exp_q_q[$], got_i[$], got_q[$];
  longint      cnt_m, held_i, held_q;
  bit          stall_prev;

  awgn_channel #(
    .DW         (DW),
    .NOISE_SHIFT(NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .snr_db    (snr_db),
    .noise_en  (noise_en),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sigma_of(input int k);
    return $rtoi(90.51 * $pow(10.0, -real'(k) / 20.0) + 0.5);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic longint model_out(input longint x, input logic [31:0] s, input int snr,
                                       input bit en);
    int     z;
    longint n, v;
    z = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]) - 510;
    n = en ? longint'($floor(real'(z * sigma_of(snr)) / 128.0)) * (longint'(1) << NS) : 0;
    v = x + n;
    if (v > MaxV) v = MaxV;
    if (v < MinV) v = MinV;
    return v;
  endfunction

  // One clock: observe and score at the falling edge, return just after the rising edge.
  task automatic tick();
    longint ei, eq;
    @(negedge clk);
    if (!reset) begin
      exp_i_q.delete();
      exp_q_q.delete();
      m_lfsr_i   = SeedDef;
      m_lfsr_q   = ~SeedDef;
      cnt_m      = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_i", longint'(out_i), held_i);
        check_eq("hold_q", longint'(out_q), held_q);
      end
      if (out_valid && out_ready) begin
        if (exp_i_q.size() == 0) begin
          check_eq("spurious_out", longint'(out_valid), 0);
        end else begin
          ei = exp_i_q.pop_front();
          eq = exp_q_q.pop_front();
          check_eq("out_i", longint'(out_i), ei);
          check_eq("out_q", longint'(out_q), eq);
          got_i.push_back(longint'(out_i));
          got_q.push_back(longint'(out_q));
        end
        cnt_m++;
      end
      stall_prev = out_valid && !out_ready;
      held_i     = longint'(out_i);
      held_q     = longint'(out_q);
      if (in_valid && in_ready) begin
        exp_i_q.push_back(model_out(longint'(in_i), m_lfsr_i, int'(snr_db), noise_en));
        exp_q_q.push_back(model_out(longint'(in_q), m_lfsr_q, int'(snr_db), noise_en));
        m_lfsr_i = lfsr_next(m_lfsr_i);
        m_lfsr_q = lfsr_next(m_lfsr_q);
      end
      if (seed_load) begin
        m_lfsr_i = (seed == 32'd0) ? SeedDef : seed;
        m_lfsr_q = ~m_lfsr_i;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    in_valid  = 1'b0;
    seed_load = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check_eq("drain_empty", longint'(exp_i_q.size()), 0);
  endtask

  task automatic run_zero(input int n, input int snr);
    in_valid  = 1'b1;
    in_i      = '0;
    in_q      = '0;
    noise_en  = 1'b1;
    snr_db    = 4'(snr);
    out_ready = 1'b1;
    repeat (n) tick();
    drain();
  endtask

  task automatic stats(input string tag, input int snr, input int n, input real sd_ref);
    real sum, sq, x, mean, sd;
    got_i.delete();
    got_q.delete();
    run_zero(n, snr);
    sum = 0.0;
    sq  = 0.0;
    foreach (got_i[k]) begin
      x = real'(got_i[k]) / real'(1 << NS);
      sum += x;
      sq  += x * x;
      x = real'(got_q[k]) / real'(1 << NS);
      sum += x;
      sq  += x * x;
    end
    mean = sum / real'(2 * got_i.size());
    sd   = $sqrt(sq / real'(2 * got_i.size()) - mean * mean);
    // Byte windows of one LFSR overlap, so the mean wanders more than independent samples
    check_eq({tag, "_mean"}, longint'(mean >= -6.0 && mean <= 6.0), 1);
    check_eq({tag, "_std"}, longint'(sd >= sd_ref * 0.97 && sd <= sd_ref * 1.03), 1);
  endtask

  initial begin
    longint a_i[$], a_q[$], p_i[$], p_q[$];
    int     r, n_sent, diffs;

    checks    = 0;
    errors    = 0;
    out_ready = 1'b1;
    in_i      = DW'(123);
    in_q      = DW'(-5);
    snr_db    = 4'd0;
    noise_en  = 1'b1;
    seed      = 32'd0;

    // Reset, with inputs offered that must be ignored
    do_reset(3);
    in_valid = 1'b1;
    reset    = 1'b0;
    #1;
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_i", longint'(out_i), 0);
    check_eq("rst_out_q", longint'(out_q), 0);
    check_eq("rst_cnt", longint'(sample_cnt), 0);
    check_eq("rst_in_ready", longint'(in_ready), 1);
    tick();
    reset = 1'b1;

    // Bypass and latency
    in_valid = 1'b1;
    noise_en = 1'b0;
    in_i     = DW'(1000);
    in_q     = DW'(-1000);
    tick();
    in_valid = 1'b0;
    check_eq("lat_c1", longint'(out_valid), 0);
    tick();
    check_eq("lat_c2", longint'(out_valid), 0);
    tick();
    check_eq("lat_c3", longint'(out_valid), 1);
    check_eq("byp_i", longint'(out_i), 1000);
    check_eq("byp_q", longint'(out_q), -1000);
    drain();

    // Random traffic, random SNR/noise_en/seed loads
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 7);
      in_i      = (r == 0) ? DW'(MaxV) : (r == 1) ? DW'(MinV) : DW'($urandom);
      in_q      = (r == 2) ? DW'(MinV) : (r == 3) ? DW'(MaxV) : DW'($urandom);
      snr_db    = 4'($urandom_range(0, 15));
      noise_en  = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      tick();
    end
    drain();
    check_eq("cnt_random", longint'(sample_cnt), cnt_m);

    // Saturation at both rails
    got_i.delete();
    got_q.delete();
    in_valid  = 1'b1;
    in_i      = DW'(MaxV);
    in_q      = DW'(MinV);
    noise_en  = 1'b1;
    snr_db    = 4'd0;
    out_ready = 1'b1;
    repeat (1000) tick();
    drain();
    diffs = 0;
    foreach (got_i[k]) if (got_i[k] < 0 || got_q[k] >= 0) diffs++;
    check_eq("sat_no_wrap", longint'(diffs), 0);
    diffs = 0;
    foreach (got_i[k]) if (got_i[k] == MaxV && got_q[k] == MinV) diffs++;
    check_eq("sat_rail_hit", longint'(diffs > 0), 1);

    // Backpressure: 10 samples, out_ready low for 5 cycles
    do_reset(2);
    got_i.delete();
    got_q.delete();
    noise_en = 1'b0;
    n_sent   = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (n_sent < 10);
      in_i      = DW'(100 * (n_sent + 1));
      in_q      = DW'(-7 * (n_sent + 1));
      #1;
      if (c >= 4 && c < 9) check_eq("bp_in_ready", longint'(in_ready), 0);
      if (in_valid && in_ready) n_sent++;
      tick();
    end
    drain();
    check_eq("bp_count", longint'(got_i.size()), 10);
    for (int k = 0; k < 10 && k < got_i.size(); k++) begin
      check_eq("bp_order_i", got_i[k], longint'(100 * (k + 1)));
      check_eq("bp_order_q", got_q[k], longint'(-7 * (k + 1)));
    end
    check_eq("bp_cnt", longint'(sample_cnt), 10);

    // Seeding: repeatability and zero-seed fallback
    do_reset(2);
    got_i.delete();
    got_q.delete();
    run_zero(256, 0);
    p_i = got_i;
    p_q = got_q;
    for (int rep = 0; rep < 3; rep++) begin
      got_i.delete();
      got_q.delete();
      seed      = (rep == 2) ? 32'd0 : 32'h1234_5678;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      run_zero(256, 0);
      diffs = 0;
      if (rep == 0) begin
        a_i = got_i;
        a_q = got_q;
        foreach (a_i[k]) if (k < p_i.size() && a_i[k] != p_i[k]) diffs++;
        check_eq("seed_differs", longint'(diffs > 0), 1);
      end else begin
        check_eq("seed_len", longint'(got_i.size()), 256);
        for (int k = 0; k < got_i.size() && k < 256; k++) begin
          if (rep == 1 && (got_i[k] != a_i[k] || got_q[k] != a_q[k])) diffs++;
          if (rep == 2 && (got_i[k] != p_i[k] || got_q[k] != p_q[k])) diffs++;
        end
        check_eq((rep == 1) ? "seed_repeat" : "seed_zero", longint'(diffs), 0);
      end
    end

    // Noise statistics at 0 dB and 8 dB
    do_reset(2);
    stats("snr0", 0, 32768, 104.5);
    stats("snr8", 8, 32768, 41.6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
